// File: rtl/cfoc_pkg.sv
// cfoc_pkg: shared constants for the carrier-frequency-offset corrector.
//   CFOC_DW / CFOC_PW / CFOC_STAGES : default sample width, phase width and
//                                     CORDIC iteration count
//   CFOC_GAIN                       : 1/K CORDIC gain compensation, Q0.15
//   CFOC_L                          : input-to-output latency in cycles
//   cfoc_atan(i)                    : atan(2^-i) in phase units (2^18 = 2*pi)
package cfoc_pkg;

    localparam int CFOC_DW     = 12;
    localparam int CFOC_PW     = 18;
    localparam int CFOC_STAGES = 12;

    // 0.607253 * 2^15, rounded
    localparam logic [15:0] CFOC_GAIN = 16'd19898;

    // input register + quadrant stage + CORDIC stages + gain/round register
    function automatic int cfoc_latency(input int stages);
        return stages + 3;
    endfunction

    localparam int CFOC_L = cfoc_latency(CFOC_STAGES);

    // atan(2^-i) * 2^18 / (2*pi), rounded to nearest
    function automatic int cfoc_atan(input int i);
        case (i)
            0:       return 32768;
            1:       return 19344;
            2:       return 10221;
            3:       return 5188;
            4:       return 2604;
            5:       return 1303;
            6:       return 652;
            7:       return 326;
            8:       return 163;
            9:       return 81;
            10:      return 41;
            11:      return 20;
            12:      return 10;
            13:      return 5;
            14:      return 3;
            15:      return 1;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/cfoc_cordic.sv
// cfoc_cordic: pipelined rotation-mode CORDIC, one register per iteration.
// Rotates (x, y) counter-clockwise by angle z; the result carries the CORDIC
// gain K ~ 1.647 (compensated by the caller).
//   clk, rst     : clock, asynchronous active-low reset
//   x, y         : W-bit signed vector in
//   z            : PW-bit signed angle in, must lie within +/- pi/2
//   rot_x, rot_y : rotated vector, STAGES cycles later
module cfoc_cordic
    import cfoc_pkg::*;
#(
    parameter int W      = CFOC_DW + 3,
    parameter int PW     = CFOC_PW,
    parameter int STAGES = CFOC_STAGES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [W-1:0]  x,
    input  logic signed [W-1:0]  y,
    input  logic signed [PW-1:0] z,
    output logic signed [W-1:0]  rot_x,
    output logic signed [W-1:0]  rot_y
);

    logic signed [W-1:0]  xr [STAGES];
    logic signed [W-1:0]  yr [STAGES];
    // the last iteration has no use for its residual angle
    logic signed [PW-1:0] zr [STAGES-1];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam logic [PW-1:0]       ATAN = PW'(cfoc_atan(i));
        // half-LSB offset so the shifted terms round instead of flooring;
        // floor bias would otherwise accumulate over the iterations
        localparam logic signed [W-1:0] RND  = W'((1 << i) >> 1);

        logic signed [W-1:0]  xp, yp, xsh, ysh;
        logic signed [PW-1:0] zp;

        if (i == 0) begin : g_first
            assign xp = x;
            assign yp = y;
            assign zp = z;
        end else begin : g_next
            assign xp = xr[i-1];
            assign yp = yr[i-1];
            assign zp = zr[i-1];
        end

        assign xsh = (xp + RND) >>> i;
        assign ysh = (yp + RND) >>> i;

        // residual angle negative -> rotate clockwise, otherwise counter-clockwise
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                xr[i] <= '0;
                yr[i] <= '0;
            end else if (zp[PW-1]) begin
                xr[i] <= xp + ysh;
                yr[i] <= yp - xsh;
            end else begin
                xr[i] <= xp - ysh;
                yr[i] <= yp + xsh;
            end
        end

        if (i < STAGES - 1) begin : g_z
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)          zr[i] <= '0;
                else if (zp[PW-1]) zr[i] <= zp + ATAN;
                else               zr[i] <= zp - ATAN;
            end
        end
    end

    assign rot_x = xr[STAGES-1];
    assign rot_y = yr[STAGES-1];

endmodule

// File: rtl/cfoc.sv
// cfoc: carrier-frequency-offset correction. Each sample is multiplied by
// e^(-j*phi), phi being a phase accumulator that restarts at each packet
// start and advances by cfo_estimated per valid sample.
//   clk, rst            : clock, asynchronous active-low reset
//   di_re, di_im        : DW-bit signed input sample, one per cycle
//   cs_start            : packet-start pulse, zeroes the phase after this sample
//   cfo_estimated       : PW-bit signed phase step (2^PW = 2*pi)
//   cfo_estimated_vld   : sample valid / phase advances
//   do_re, do_im        : corrected sample, L = STAGES + 3 cycles later
//   do_vld              : cfo_estimated_vld delayed by L
// Valid semantics: do_vld qualifies do_re/do_im on the same cycle; there is
// no ready, the pipeline never stalls, and data is don't-care while do_vld=0.
// Build option: define CFOC_SAT_EN to saturate the outputs to DW bits
// instead of wrapping.
module cfoc
    import cfoc_pkg::*;
#(
    parameter int DW     = CFOC_DW,
    parameter int PW     = CFOC_PW,
    parameter int STAGES = CFOC_STAGES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] di_re,
    input  logic signed [DW-1:0] di_im,
    input  logic                 cs_start,
    input  logic signed [PW-1:0] cfo_estimated,
    input  logic                 cfo_estimated_vld,
    output logic signed [DW-1:0] do_re,
    output logic signed [DW-1:0] do_im,
    output logic                 do_vld
);

    // one extra bit of headroom for CORDIC growth, one sign-safe guard bit and
    // one fractional bit below the input LSB
    localparam int W     = DW + 3;
    localparam int L     = cfoc_latency(STAGES);
    localparam int FRAC  = 16;      // 15 gain fraction bits + 1 internal fraction bit
    localparam int PRODW = W + 17;

    localparam logic [PW-1:0]           QUARTER = {2'b01, {(PW-2){1'b0}}};
    localparam logic signed [PRODW-1:0] HALF    = PRODW'(1 << (FRAC - 1));
    localparam logic signed [PRODW-1:0] SMAX    = PRODW'((1 << (DW - 1)) - 1);
    localparam logic signed [PRODW-1:0] SMIN    = -SMAX - PRODW'(1);

    // phase accumulator, wraps modulo 2^PW
    logic [PW-1:0] acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   acc <= '0;
        else if (cs_start)          acc <= '0;
        else if (cfo_estimated_vld) acc <= acc + cfo_estimated;
    end

    // input register: the sample is paired with the phase before this cycle's update
    logic signed [DW-1:0] in_re, in_im;
    logic [PW-1:0]        in_phi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_re  <= '0;
            in_im  <= '0;
            in_phi <= '0;
        end else begin
            in_re  <= di_re;
            in_im  <= di_im;
            in_phi <= acc;
        end
    end

    // quadrant pre-rotation: rotate by -phi, folding the angle into +/- pi/2
    logic [PW-1:0]       zn, qz_d;
    logic signed [W-1:0] xe, ye, qx_d, qy_d;

    always_comb begin
        zn   = -in_phi;
        xe   = {{2{in_re[DW-1]}}, in_re, 1'b0};
        ye   = {{2{in_im[DW-1]}}, in_im, 1'b0};
        qx_d = xe;
        qy_d = ye;
        qz_d = zn;
        case (zn[PW-1 -: 2])
            2'b01: begin                 // [pi/2, pi): pre-rotate by +pi/2
                qx_d = -ye;
                qy_d = xe;
                qz_d = zn - QUARTER;
            end
            2'b10: begin                 // [-pi, -pi/2): pre-rotate by -pi/2
                qx_d = ye;
                qy_d = -xe;
                qz_d = zn + QUARTER;
            end
            default: ;
        endcase
    end

    logic signed [W-1:0]  qx, qy;
    logic signed [PW-1:0] qz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            qx <= '0;
            qy <= '0;
            qz <= '0;
        end else begin
            qx <= qx_d;
            qy <= qy_d;
            qz <= qz_d;
        end
    end

    logic signed [W-1:0] cx, cy;

    cfoc_cordic #(
        .W      (W),
        .PW     (PW),
        .STAGES (STAGES)
    ) u_cordic (
        .clk   (clk),
        .rst   (rst),
        .x     (qx),
        .y     (qy),
        .z     (qz),
        .rot_x (cx),
        .rot_y (cy)
    );

    // gain compensation, round half up, then saturate or wrap to DW bits
    function automatic logic signed [DW-1:0] finish(input logic signed [W-1:0] v);
        logic signed [PRODW-1:0] p;
        p = PRODW'(v) * PRODW'($signed({1'b0, CFOC_GAIN}));
        p = (p + HALF) >>> FRAC;
`ifdef CFOC_SAT_EN
        if (p > SMAX) return {1'b0, {(DW-1){1'b1}}};
        if (p < SMIN) return {1'b1, {(DW-1){1'b0}}};
`endif
        return p[DW-1:0];
    endfunction

    logic [L-1:0] vld_sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            do_re  <= '0;
            do_im  <= '0;
            vld_sr <= '0;
        end else begin
            do_re  <= finish(cx);
            do_im  <= finish(cy);
            vld_sr <= {vld_sr[L-2:0], cfo_estimated_vld};
        end
    end

    assign do_vld = vld_sr[L-1];

endmodule

// File: tb/tb_cfoc.sv
`timescale 1ns/1ps
module tb_cfoc;

    localparam int  DW     = 12;
    localparam int  PW     = 18;
    localparam int  STAGES = 12;
    localparam int  L      = STAGES + 3;
    localparam real TWO_PI = 6.283185307179586;
    localparam real PI     = 3.141592653589793;
    localparam int  TOL    = 4;            // model tolerance for random traffic, LSB
    localparam real PH_TOL = 0.001953125;  // 2^-9 rad

    // ---------------- clock / reset ----------------
    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] di_re = '0, di_im = '0;
    logic                 cs_start = 1'b0;
    logic signed [PW-1:0] cfo_estimated = '0;
    logic                 cfo_estimated_vld = 1'b0;
    logic signed [DW-1:0] do_re, do_im;
    logic                 do_vld;

    always #5 clk = ~clk;

    cfoc #(.DW(DW), .PW(PW), .STAGES(STAGES)) dut (
        .clk               (clk),
        .rst               (rst),
        .di_re             (di_re),
        .di_im             (di_im),
        .cs_start          (cs_start),
        .cfo_estimated     (cfo_estimated),
        .cfo_estimated_vld (cfo_estimated_vld),
        .do_re             (do_re),
        .do_im             (do_im),
        .do_vld            (do_vld)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        bit  vld;
        real ex_re;
        real ex_im;
        bit  lit;
        int  lit_re;
        int  lit_im;
        int  lit_tol;
        bit  ph;
        int  in_re;
        int  in_im;
        real ph_exp;
    } exp_t;

    exp_t exp_q[$];
    exp_t ce;
    int   checks = 0;
    int   errors = 0;
    int   m_acc = 0;          // model phase, 0 .. 2^18-1
    bit   checking = 1'b0;

    bit   lit_en = 1'b0;
    int   lit_re = 0, lit_im = 0, lit_tol = 0;
    bit   ph_en = 1'b0;
    real  ph_exp = 0.0;

    task automatic chk_int(input string name, input int act, input int req, input int tol);
        checks++;
        if (act > req + tol || act < req - tol) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (+/-%0d)", name, act, req, tol);
        end
    endtask

    // compares against the ideal rotated value after the DW-bit output mapping
    function automatic bit close(input int act, input real ideal, input int tol);
        real d;
`ifdef CFOC_SAT_EN
        real c;
        c = ideal;
        if (c > 2047.0)  c = 2047.0;
        if (c < -2048.0) c = -2048.0;
        d = real'(act) - c;
`else
        d = real'(act) - ideal;
        d = d - 4096.0 * $floor((d + 2048.0) / 4096.0);
`endif
        return (d <= real'(tol)) && (d >= -real'(tol));
    endfunction

    task automatic chk_model(input string name, input int act, input real ideal);
        checks++;
        if (!close(act, ideal, TOL)) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%.2f (+/-%0d)", name, act, ideal, TOL);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL queue_underrun: actual=empty required=entry");
            end else begin
                ce = exp_q.pop_front();
                chk_int("do_vld", int'(do_vld), int'(ce.vld), 0);
                if (ce.vld) begin
                    chk_model("model_re", int'(do_re), ce.ex_re);
                    chk_model("model_im", int'(do_im), ce.ex_im);
                end
                if (ce.lit) begin
                    chk_int("literal_re", int'(do_re), ce.lit_re, ce.lit_tol);
                    chk_int("literal_im", int'(do_im), ce.lit_im, ce.lit_tol);
                end
                if (ce.ph) begin
                    real d;
                    d = $atan2(real'(do_im), real'(do_re))
                        - $atan2(real'(ce.in_im), real'(ce.in_re)) - ce.ph_exp;
                    d = d - TWO_PI * $floor((d + PI) / TWO_PI);
                    checks++;
                    if (d > PH_TOL || d < -PH_TOL) begin
                        errors++;
                        $display("FAIL phase: actual_err=%f rad required=|err|<=%f", d, PH_TOL);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // one sample per cycle; the model pairs it with the phase before the update
    task automatic step(input int re, input int im, input bit cs, input int cfo, input bit vld);
        exp_t e;
        real  phi;
        @(posedge clk);
        #1;
        if (!rst) begin
            rst      = 1'b1;
            checking = 1'b1;
        end
        di_re             = re[DW-1:0];
        di_im             = im[DW-1:0];
        cs_start          = cs;
        cfo_estimated     = cfo[PW-1:0];
        cfo_estimated_vld = vld;
        phi      = real'(m_acc) * TWO_PI / 262144.0;
        e.vld    = vld;
        e.ex_re  = real'(re) * $cos(phi) + real'(im) * $sin(phi);
        e.ex_im  = real'(im) * $cos(phi) - real'(re) * $sin(phi);
        e.lit    = lit_en;
        e.lit_re = lit_re;
        e.lit_im = lit_im;
        e.lit_tol = lit_tol;
        e.ph     = ph_en;
        e.in_re  = re;
        e.in_im  = im;
        e.ph_exp = ph_exp;
        exp_q.push_back(e);
        lit_en = 1'b0;
        ph_en  = 1'b0;
        if (cs)       m_acc = 0;
        else if (vld) m_acc = (m_acc + cfo) & 32'h3FFFF;
    endtask

    task automatic set_lit(input int re, input int im, input int tol);
        lit_en  = 1'b1;
        lit_re  = re;
        lit_im  = im;
        lit_tol = tol;
    endtask

    // holds reset for n cycles; released by the next step()
    task automatic do_reset(input int n);
        exp_t z;
        @(posedge clk);
        #1;
        checking          = 1'b0;
        rst               = 1'b0;
        di_re             = '0;
        di_im             = '0;
        cs_start          = 1'b0;
        cfo_estimated     = '0;
        cfo_estimated_vld = 1'b0;
        #1;
        chk_int("reset_do_vld", int'(do_vld), 0, 0);
        chk_int("reset_do_re", int'(do_re), 0, 0);
        chk_int("reset_do_im", int'(do_im), 0, 0);
        repeat (n - 1) @(posedge clk);
        exp_q.delete();
        z = '{vld: 1'b0, ex_re: 0.0, ex_im: 0.0, lit: 1'b1, lit_re: 0, lit_im: 0,
              lit_tol: 0, ph: 1'b0, in_re: 0, in_im: 0, ph_exp: 0.0};
        for (int i = 0; i < L; i++) exp_q.push_back(z);
        m_acc = 0;
    endtask

    function automatic int rnd_s(input int half);
        return int'($urandom_range(2 * half - 1)) - half;
    endfunction

    // ---------------- stimulus ----------------
    int q_re[4] = '{1000, 0, -1000, 0};
    int q_im[4] = '{0, -1000, 0, 1000};

    initial begin
        do_reset(3);

        // zero offset
        for (int k = 0; k < 20; k++) begin
            if (k == 0) set_lit(1000, -500, 1);
            step(1000, -500, k == 0, 0, 1'b1);
        end
        for (int k = 0; k < 5; k++) step(rnd_s(2048), rnd_s(2048), 1'b0, 0, 1'b0);

        // quarter-turn steps with a restart at sample 11
        for (int k = 0; k < 24; k++) begin
            if (k >= 1) begin
                int idx;
                idx = (k <= 11) ? (k - 1) : (k - 12);
                set_lit(q_re[idx % 4], q_im[idx % 4], 2);
            end
            step(1000, 0, (k == 0) || (k == 11), 65536, 1'b1);
        end

        // large input, -pi/4 step
        for (int k = 0; k < 6; k++) begin
`ifdef CFOC_SAT_EN
            if (k == 2) set_lit(0, 2047, 2);
`else
            if (k == 2) set_lit(0, -1201, 2);
`endif
            step(2047, 2047, k == 0, -32768, 1'b1);
        end

        // random traffic with a mid-stream reset
        for (int k = 0; k < 100; k++)
            step(rnd_s(2048), rnd_s(2048), $urandom_range(49) == 0, rnd_s(131072),
                 $urandom_range(4) != 0);
        do_reset(3);
        for (int k = 0; k < 200; k++)
            step(rnd_s(2048), rnd_s(2048), $urandom_range(49) == 0, rnd_s(131072),
                 $urandom_range(4) != 0);

        // realistic offset over a long packet
        for (int n = 0; n <= 5001; n++) begin
            if (n >= 2 && ((n - 1) % 500 == 0)) begin
                ph_en  = 1'b1;
                ph_exp = 84.0 * real'(n - 1) * TWO_PI / 262144.0;
            end
            step(1400, 1400, n == 0, -84, 1'b1);
        end

        // drain
        for (int k = 0; k <= L; k++) step(rnd_s(2048), rnd_s(2048), 1'b0, 0, 1'b0);
        @(negedge clk);
        #1;
        checking = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
